// File: rtl/joystick_sega_scan.sv
// Select/load/shift sequencer for the dual-DB9 serial joystick splitter.
// Walks 8 select phases per scan and publishes both pads' 12-bit button state at once.
module joystick_sega_scan #(
    parameter int CLK_DIV = 16,
    parameter int SETTLE  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trig,
    output logic        joySl,
    output logic        joyCk,
    output logic        joyLd,
    input  logic        joyD,
    output logic [11:0] joy1,
    output logic [11:0] joy2,
    output logic [1:0]  joy1Type,
    output logic [1:0]  joy2Type,
    output logic        valid,
    output logic        busy,
    output logic [2:0]  dbg_state
);
    localparam int            DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX    = DW'(CLK_DIV - 1);
    localparam logic [4:0]    SETTLE_MAX = 5'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_LOAD   = 3'd2,
        S_SHIFT  = 3'd3,
        S_STORE  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_div;
    logic          w_tick;
    logic          w_start;
    logic          r_pending;
    logic [2:0]    r_phase;
    logic [4:0]    r_cnt;
    logic          r_ck;
    logic [15:0]   r_sr;
    logic [7:0]    w_byte [2];
    logic [11:0]   r_btn [2];
    logic [1:0]    r_sega;
    logic [1:0]    r_six;
    logic [11:0]   r_joy1;
    logic [11:0]   r_joy2;
    logic [1:0]    r_type1;
    logic [1:0]    r_type2;
    logic          r_valid;

    function automatic logic [11:0] f_mask(input logic [11:0] btn, input logic sega, input logic six);
        return {six ? btn[11:8] : 4'h0, sega ? btn[7:6] : 2'b00, btn[5:0]};
    endfunction

    function automatic logic [1:0] f_type(input logic sega, input logic six);
        return six ? 2'd2 : (sega ? 2'd1 : 2'd0);
    endfunction

    assign w_tick    = (r_div == DIV_MAX);
    // trig has no ready: it starts a scan on the next idle tick or waits in a 1-deep pending flag;
    // valid is a 1-cycle strobe with no backpressure, coincident with the new joy*/joy*Type values.
    assign w_start   = (r_state == S_IDLE) && w_tick && (r_pending || trig);
    assign w_byte[0] = r_sr[7:0];
    assign w_byte[1] = r_sr[15:8];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            if (w_start)
                r_pending <= 1'b0;
            else if (trig)
                r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_SETTLE;
            S_SETTLE: if (w_tick && r_cnt == SETTLE_MAX) w_next = S_LOAD;
            S_LOAD:   if (w_tick) w_next = S_SHIFT;
            S_SHIFT:  if (w_tick && r_cnt == 5'd31) w_next = S_STORE;
            S_STORE:  if (w_tick) w_next = (r_phase == 3'd7) ? S_IDLE : S_SETTLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        joySl     = 1'b1;
        joyLd     = 1'b1;
        busy      = r_valid;
        dbg_state = r_state;
        if (r_state != S_IDLE) begin
            joySl = ~r_phase[0];
            busy  = 1'b1;
        end
        if (r_state == S_LOAD)
            joyLd = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase <= '0;
            r_cnt   <= '0;
            r_ck    <= 1'b0;
            r_sr    <= '0;
            r_sega  <= '0;
            r_six   <= '0;
            r_joy1  <= '0;
            r_joy2  <= '0;
            r_type1 <= '0;
            r_type2 <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < 2; i++)
                r_btn[i] <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    S_IDLE: if (w_start) begin
                        r_phase <= '0;
                        r_cnt   <= '0;
                        r_sega  <= '0;
                        r_six   <= '0;
                        for (int i = 0; i < 2; i++)
                            r_btn[i] <= '0;
                    end
                    S_SETTLE: r_cnt <= (r_cnt == SETTLE_MAX) ? 5'd0 : r_cnt + 5'd1;
                    S_LOAD:   r_cnt <= '0;
                    S_SHIFT: begin
                        r_cnt <= r_cnt + 5'd1;
                        r_ck  <= ~r_ck;
                        if (r_ck)
                            r_sr <= {r_sr[14:0], ~joyD};
                    end
                    S_STORE: begin
                        r_cnt   <= '0;
                        r_phase <= r_phase + 3'd1;
                        // Byte layout: [0]U [1]D [2]L [3]R [4]B [5]C; each phase reuses those slots.
                        for (int i = 0; i < 2; i++) begin
                            case (r_phase)
                                3'd0: r_btn[i][5:0] <= {w_byte[i][5], w_byte[i][4], w_byte[i][0],
                                                        w_byte[i][1], w_byte[i][2], w_byte[i][3]};
                                3'd1: begin
                                    r_sega[i] <= w_byte[i][2] & w_byte[i][3];
                                    if (w_byte[i][2] & w_byte[i][3])
                                        r_btn[i][7:6] <= {w_byte[i][5], w_byte[i][4]};
                                end
                                3'd5: r_six[i] <= r_sega[i] & (&w_byte[i][3:0]);
                                3'd6: if (r_six[i])
                                    r_btn[i][11:8] <= {w_byte[i][3], w_byte[i][0],
                                                       w_byte[i][1], w_byte[i][2]};
                                default: ;
                            endcase
                        end
                        if (r_phase == 3'd7) begin
                            r_joy1  <= f_mask(r_btn[0], r_sega[0], r_six[0]);
                            r_joy2  <= f_mask(r_btn[1], r_sega[1], r_six[1]);
                            r_type1 <= f_type(r_sega[0], r_six[0]);
                            r_type2 <= f_type(r_sega[1], r_six[1]);
                            r_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign joyCk    = r_ck;
    assign joy1     = r_joy1;
    assign joy2     = r_joy2;
    assign joy1Type = r_type1;
    assign joy2Type = r_type2;
    assign valid    = r_valid;
endmodule
